riscv_multicycle_top: RTL and testbench
=======================================

Name: riscv_multicycle_top

Overview:
- Top level of a multicycle RV32I-subset core: PC/fetch unit, instruction memory, decoder, 32x32 register file, ALU, data memory and control FSM.
- Only clock and reset are exposed. Memories and registers are preloaded by the bench through hierarchy.
- One instruction completes every 3–5 cycles. There is no pipelining.

Parameters:
- IMEM_WORDS, 64, instruction memory depth in 32-bit words, word-addressed by pc[31:2] modulo depth.
- DMEM_WORDS, 64, data memory depth in 32-bit words.

Ports:
- clk  input  1  single system clock; all state updates on the rising edge.
- reset  input  1  asynchronous, active-low reset.

Behaviour:
- Reset (reset low):
  - Asynchronously forces pc_cur=0, FSM=FETCH, pc_src=0.
  - Register file and memories are not cleared.
  - The decode path stays live, so opcode/imm_ext/pc_target reflect imem[0] while reset is held.
- Instruction: combinational read instr = imem[pc_cur[31:2]]; pc_cur is stable for the whole instruction.
- Decode:
  - opcode = instr[6:0]; rs1 = [19:15], rs2 = [24:20], rd = [11:7].
  - imm_ext sign-extended by format: I (addi/lw), S (sw), B (beq, bit0=0), J (jal).
  - R-type imm_ext = 0.
- pc_target = pc_cur + imm_ext, combinational at all times.
- Register file:
  - 2 combinational read ports, 1 write port written on the clock edge.
  - x0 reads 0 and ignores writes.
- ALU:
  - a = rs1 value.
  - b = rs2 value, or imm_ext for I/S types.
  - Ops: add, sub, and, or, xor, slt.
  - zero = (result == 0), combinational.
  - In FETCH and DECODE the ALU performs sub on rs1/rs2 values.
- FSM states: FETCH, DECODE, EXECUTE, MEMADR, MEMRD, MEMWB, MEMWR, ALUWB, BRANCH, JAL.
  - FETCH -> DECODE.
  - DECODE -> BRANCH (beq), EXECUTE (R-type, addi), MEMADR (lw/sw), JAL (jal).
  - Unknown opcode: stay in FETCH, pc unchanged.
  - BRANCH (ALU sub rs1-rs2): pc_src = zero. On exit, pc_cur <= pc_src ? pc_target : pc_cur+4. Next: FETCH.
  - EXECUTE: ALU op from funct3/funct7 (sub when funct7[5]=1 for R-type). -> ALUWB.
  - ALUWB: rd <= registered ALU result; pc_cur <= pc_cur+4. -> FETCH.
  - MEMADR: address = rs1 + imm. -> MEMRD (lw) or MEMWR (sw).
  - MEMRD -> MEMWB.
  - MEMWB: rd <= dmem word; pc+4. -> FETCH.
  - MEMWR: dmem <= rs2; pc+4. -> FETCH.
  - JAL: rd <= pc_cur+4; pc_cur <= pc_target. -> FETCH.
- pc_src is 1 only in BRANCH with zero=1.
  - A zero ALU result from any non-beq instruction never redirects the PC.
- Cycles per instruction: beq 3, jal 3, R/I-type ALU 4, sw 4, lw 5.
- PC arithmetic wraps modulo 2^32; negative targets are allowed (0 + 0xFFFFFFF4 = 0xFFFFFFF4).
- Reset mid-instruction aborts it: no register write or memory write occurs after reset is asserted.
- Internal probe points (required for verification): opcode, imm_ext, pc_cur, pc_target, ALU a, b, zero, pc_src, register array.

Test Plan:
- Taken beq:
  - Stimulus: imem[0]=0xFE420AE3 (beq x4,x4,-12); x4=42; hold reset low then release.
  - During reset: opcode=1100011, pc_cur=0, imm_ext=0xFFFFFFF4.
  - Cycle1: a=b=0x2A, zero=1.
  - Cycle2: pc_src=1, pc_target=0xFFFFFFF4.
  - Cycle3: pc_cur=0xFFFFFFF4.
- Not-taken beq:
  - Stimulus: beq x1,x2,+16 (0x00208863); x1=42, x2=43.
  - imm_ext=0x10; a=0x2A, b=0x2B, zero=0.
  - pc_src=0, pc_target=0x10.
  - After update: pc_cur=4, pc_target=0x14.
- Zero result without branch:
  - Stimulus: sub x1,x1,x1 with x1=1.
  - EXECUTE: zero=1, pc_src=0.
  - pc_cur stays 0 through ALUWB; then pc_cur=4, x1=0, no jump.
- addi/lw/sw:
  - Stimulus: addi x5,x0,8; then sw x5,4(x0); then lw x6,4(x0).
  - Results: x5=8, dmem[1]=8, x6=8, pc=12 after 13 cycles.
- jal:
  - Stimulus: jal x1,+8 at pc 0.
  - Results: x1=4, pc_cur=8 after 3 cycles.
- Reset mid-instruction:
  - Stimulus: assert reset during ALUWB of add x3,x1,x2.
  - Results: pc_cur=0 immediately, x3 unchanged, FSM=FETCH.

Source files
------------

// File: rtl/riscv_multicycle_top.sv
// riscv_multicycle_top: multicycle RV32I-subset core (add/sub/and/or/xor/slt, addi, lw, sw, beq, jal)
module riscv_multicycle_top #(
  parameter int IMEM_WORDS = 64,
  parameter int DMEM_WORDS = 64
) (
  input logic clk,
  input logic reset
);
  localparam int IW = $clog2(IMEM_WORDS);
  localparam int DW = $clog2(DMEM_WORDS);
  localparam logic [6:0] OP_R = 7'b0110011, OP_I = 7'b0010011, OP_LW = 7'b0000011;
  localparam logic [6:0] OP_SW = 7'b0100011, OP_BEQ = 7'b1100011, OP_JAL = 7'b1101111;
  typedef enum logic [3:0] {FETCH, DECODE, EXECUTE, MEMADR, MEMRD, MEMWB, MEMWR, ALUWB, BRANCH, JAL} state_t;
  state_t state, state_nx;
  logic [31:0] imem [IMEM_WORDS];
  logic [31:0] dmem [DMEM_WORDS];
  logic [31:0] regs [32];
  logic [31:0] pc_cur, pc_nx, pc_plus4, pc_target, instr, imm_ext, a, b, rs2_val, result, alu_out, wd;
  logic [6:0] opcode;
  logic [4:0] rs1, rs2, rd;
  logic [2:0] funct3, f3;
  logic zero, pc_src, known, sub_op, we;
  assign instr = imem[pc_cur[IW+1:2]];
  assign opcode = instr[6:0];
  assign rd = instr[11:7];
  assign funct3 = instr[14:12];
  assign rs1 = instr[19:15];
  assign rs2 = instr[24:20];
  assign known = opcode == OP_R || opcode == OP_I || opcode == OP_LW || opcode == OP_SW ||
                 opcode == OP_BEQ || opcode == OP_JAL;
  always_comb
    imm_ext = (opcode == OP_I || opcode == OP_LW) ? {{20{instr[31]}}, instr[31:20]}
            : opcode == OP_SW  ? {{20{instr[31]}}, instr[31:25], instr[11:7]}
            : opcode == OP_BEQ ? {{19{instr[31]}}, instr[31], instr[7], instr[30:25], instr[11:8], 1'b0}
            : opcode == OP_JAL ? {{11{instr[31]}}, instr[31], instr[19:12], instr[20], instr[30:21], 1'b0}
            : '0;
  assign pc_target = pc_cur + imm_ext;
  assign pc_plus4 = pc_cur + 32'd4;
  assign a = rs1 == 5'd0 ? '0 : regs[rs1];
  assign rs2_val = rs2 == 5'd0 ? '0 : regs[rs2];
  assign b = (state == FETCH || state == DECODE || opcode == OP_R || opcode == OP_BEQ) ? rs2_val : imm_ext;
  // Outside EXECUTE the ALU is add for address generation and sub everywhere else
  assign f3 = state == EXECUTE ? funct3 : 3'b000;
  assign sub_op = state == EXECUTE ? (opcode == OP_R && instr[30]) : state != MEMADR;
  always_comb
    result = f3 == 3'b111 ? a & b
           : f3 == 3'b110 ? a | b
           : f3 == 3'b100 ? a ^ b
           : f3 == 3'b010 ? {31'd0, $signed(a) < $signed(b)}
           : sub_op ? a - b : a + b;
  assign zero = result == 32'd0;
  assign pc_src = state == BRANCH && zero;
  always_comb begin
    state_nx = FETCH;
    pc_nx = pc_cur;
    case (state)
      FETCH: state_nx = known ? DECODE : FETCH;
      DECODE: state_nx = opcode == OP_BEQ ? BRANCH : opcode == OP_JAL ? JAL
                       : (opcode == OP_LW || opcode == OP_SW) ? MEMADR : EXECUTE;
      EXECUTE: state_nx = ALUWB;
      MEMADR: state_nx = opcode == OP_LW ? MEMRD : MEMWR;
      MEMRD: state_nx = MEMWB;
      BRANCH: pc_nx = pc_src ? pc_target : pc_plus4;
      JAL: pc_nx = pc_target;
      default: pc_nx = pc_plus4;
    endcase
  end
  always_ff @(posedge clk or negedge reset)
    if (!reset) begin
      state <= FETCH;
      pc_cur <= '0;
    end else begin
      state <= state_nx;
      pc_cur <= pc_nx;
    end
  // Writes are gated by reset so an aborted instruction never commits
  assign wd = state == JAL ? pc_plus4 : state == MEMWB ? dmem[alu_out[DW+1:2]] : alu_out;
  assign we = reset && rd != 5'd0 && (state == ALUWB || state == MEMWB || state == JAL);
  always_ff @(posedge clk) begin
    if (state == EXECUTE || state == MEMADR) alu_out <= result;
    if (we) regs[rd] <= wd;
    if (reset && state == MEMWR) dmem[alu_out[DW+1:2]] <= rs2_val;
  end
endmodule

// File: tb/tb_riscv_multicycle_top.sv
// tb_riscv_multicycle_top: vector table, directed corner cases and random programs vs an ISA-level model
module tb_riscv_multicycle_top;
  logic clk = 1'b0;
  logic reset = 1'b0;
  int checks = 0;
  int errors = 0;
  riscv_multicycle_top dut (.clk(clk), .reset(reset));
  always #5 clk = ~clk;
  typedef struct {
    logic [31:0] instr;
    logic [31:0] v1;
    logic [31:0] v2;
    int rd;
    logic [31:0] exp_rd;
    logic [31:0] exp_pc;
    int cyc;
  } vec_t;
  typedef struct {
    int kind;
    int f;
    logic [4:0] rd;
    logic [4:0] rs1;
    logic [4:0] rs2;
    logic [31:0] imm;
  } ins_t;
  vec_t vecs[$];
  ins_t prog[64];
  logic [31:0] m_regs[32];
  logic [31:0] m_dmem[64];
  logic [31:0] m_pc;
  task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got %h expected %h", name, act, exp);
    end
  endtask
  function automatic logic [31:0] enc_r(logic [6:0] f7, logic [2:0] f3, logic [4:0] rd, logic [4:0] rs1, logic [4:0] rs2);
    return {f7, rs2, rs1, f3, rd, 7'b0110011};
  endfunction
  function automatic logic [31:0] enc_i(logic [11:0] imm, logic [4:0] rs1, logic [2:0] f3, logic [4:0] rd, logic [6:0] op);
    return {imm, rs1, f3, rd, op};
  endfunction
  function automatic logic [31:0] enc_s(logic [11:0] imm, logic [4:0] rs2, logic [4:0] rs1);
    return {imm[11:5], rs2, rs1, 3'b010, imm[4:0], 7'b0100011};
  endfunction
  function automatic logic [31:0] enc_b(logic [12:0] imm, logic [4:0] rs1, logic [4:0] rs2);
    return {imm[12], imm[10:5], rs2, rs1, 3'b000, imm[4:1], imm[11], 7'b1100011};
  endfunction
  function automatic logic [31:0] enc_j(logic [20:0] imm, logic [4:0] rd);
    return {imm[20], imm[10:1], imm[11], imm[19:12], rd, 7'b1101111};
  endfunction
  function automatic logic [31:0] enc(ins_t i);
    logic [2:0] f3s[6] = '{3'b000, 3'b000, 3'b111, 3'b110, 3'b100, 3'b010};
    case (i.kind)
      0: return enc_r(i.f == 1 ? 7'h20 : 7'h00, f3s[i.f], i.rd, i.rs1, i.rs2);
      1: return enc_i(i.imm[11:0], i.rs1, 3'b000, i.rd, 7'b0010011);
      2: return enc_s(i.imm[11:0], i.rs2, i.rs1);
      3: return enc_i(i.imm[11:0], i.rs1, 3'b010, i.rd, 7'b0000011);
      4: return enc_b(i.imm[12:0], i.rs1, i.rs2);
      default: return enc_j(i.imm[20:0], i.rd);
    endcase
  endfunction
  function automatic ins_t rand_ins();
    ins_t i;
    int t;
    logic [31:0] r;
    i.kind = int'($urandom_range(0, 5));
    i.f = int'($urandom_range(0, 5));
    i.rd = 5'($urandom_range(0, 7));
    i.rs1 = 5'($urandom_range(0, i.kind == 4 ? 3 : 7));
    i.rs2 = 5'($urandom_range(0, i.kind == 4 ? 3 : 7));
    r = $urandom;
    t = int'($urandom_range(0, 32));
    i.imm = i.kind >= 4 ? 32'((t - 16) * 4) : {{20{r[11]}}, r[11:0]};
    return i;
  endfunction
  function automatic logic [31:0] rv(logic [4:0] r);
    return r == 5'd0 ? 32'd0 : m_regs[r];
  endfunction
  function automatic void wr(logic [4:0] r, logic [31:0] v);
    if (r != 5'd0) m_regs[r] = v;
  endfunction
  // Executes one instruction at ISA level and returns its cycle cost
  function automatic int step();
    ins_t i = prog[m_pc[7:2]];
    logic [31:0] x = rv(i.rs1);
    logic [31:0] y = rv(i.rs2);
    logic [31:0] addr = x + i.imm;
    int cost = 4;
    case (i.kind)
      0: begin
        case (i.f)
          0: wr(i.rd, x + y);
          1: wr(i.rd, x - y);
          2: wr(i.rd, x & y);
          3: wr(i.rd, x | y);
          4: wr(i.rd, x ^ y);
          default: wr(i.rd, ($signed(x) < $signed(y)) ? 32'd1 : 32'd0);
        endcase
        m_pc = m_pc + 4;
      end
      1: begin wr(i.rd, x + i.imm); m_pc = m_pc + 4; end
      2: begin m_dmem[addr[7:2]] = y; m_pc = m_pc + 4; end
      3: begin wr(i.rd, m_dmem[addr[7:2]]); m_pc = m_pc + 4; cost = 5; end
      4: begin m_pc = (x == y) ? m_pc + i.imm : m_pc + 4; cost = 3; end
      default: begin wr(i.rd, m_pc + 4); m_pc = m_pc + i.imm; cost = 3; end
    endcase
    return cost;
  endfunction
  task automatic clear_all();
    reset = 1'b0;
    for (int i = 0; i < 64; i++) begin
      dut.imem[i] = '0;
      dut.dmem[i] = '0;
    end
    for (int i = 0; i < 32; i++) dut.regs[i] = '0;
  endtask
  task automatic start();
    @(negedge clk);
    reset = 1'b1;
  endtask
  task automatic cycles(int n);
    repeat (n) @(negedge clk);
  endtask
  initial begin
    int cyc;
    vecs.push_back('{enc_r(7'h00, 3'b000, 5'd3, 5'd1, 5'd2), 32'd5, 32'd7, 3, 32'd12, 32'd4, 4});
    vecs.push_back('{enc_r(7'h20, 3'b000, 5'd3, 5'd1, 5'd2), 32'd5, 32'd7, 3, 32'hFFFFFFFE, 32'd4, 4});
    vecs.push_back('{enc_r(7'h00, 3'b111, 5'd3, 5'd1, 5'd2), 32'hF0F01234, 32'h0FF0FF00, 3, 32'h00F01200, 32'd4, 4});
    vecs.push_back('{enc_r(7'h00, 3'b110, 5'd3, 5'd1, 5'd2), 32'hF0F01234, 32'h0FF0FF00, 3, 32'hFFF0FF34, 32'd4, 4});
    vecs.push_back('{enc_r(7'h00, 3'b100, 5'd3, 5'd1, 5'd2), 32'hF0F01234, 32'h0FF0FF00, 3, 32'hFF00ED34, 32'd4, 4});
    vecs.push_back('{enc_r(7'h00, 3'b010, 5'd3, 5'd1, 5'd2), 32'hFFFFFFFF, 32'd1, 3, 32'd1, 32'd4, 4});
    vecs.push_back('{enc_r(7'h00, 3'b010, 5'd3, 5'd1, 5'd2), 32'd1, 32'hFFFFFFFF, 3, 32'd0, 32'd4, 4});
    vecs.push_back('{enc_i(12'hFFF, 5'd1, 3'b000, 5'd4, 7'b0010011), 32'd0, 32'd0, 4, 32'hFFFFFFFF, 32'd4, 4});
    vecs.push_back('{enc_j(21'd8, 5'd5), 32'd0, 32'd0, 5, 32'd4, 32'd8, 3});
    vecs.push_back('{enc_b(13'd16, 5'd1, 5'd2), 32'd9, 32'd9, 0, 32'd0, 32'h10, 3});
    vecs.push_back('{enc_b(13'd16, 5'd1, 5'd2), 32'd9, 32'd8, 0, 32'd0, 32'd4, 3});
    vecs.push_back('{enc_b(13'h1FF4, 5'd1, 5'd2), 32'd3, 32'd3, 0, 32'd0, 32'hFFFFFFF4, 3});
    vecs.push_back('{enc_r(7'h00, 3'b000, 5'd0, 5'd1, 5'd2), 32'd5, 32'd7, 0, 32'd0, 32'd4, 4});
    @(negedge clk);
    foreach (vecs[k]) begin
      clear_all();
      dut.imem[0] = vecs[k].instr;
      dut.regs[1] = vecs[k].v1;
      dut.regs[2] = vecs[k].v2;
      start();
      cycles(vecs[k].cyc - 1);
      chk($sformatf("vec%0d_pc_hold", k), dut.pc_cur, 32'd0);
      cycles(1);
      chk($sformatf("vec%0d_pc", k), dut.pc_cur, vecs[k].exp_pc);
      chk($sformatf("vec%0d_rd", k), dut.regs[vecs[k].rd], vecs[k].exp_rd);
    end
    // taken beq to a negative target
    clear_all();
    dut.imem[0] = 32'hFE420AE3;
    dut.regs[4] = 32'd42;
    #1;
    chk("rst_opcode", {25'd0, dut.opcode}, 32'h63);
    chk("rst_pc", dut.pc_cur, 32'd0);
    chk("rst_imm", dut.imm_ext, 32'hFFFFFFF4);
    start();
    cycles(1);
    chk("tk_a", dut.a, 32'h2A);
    chk("tk_b", dut.b, 32'h2A);
    chk("tk_zero", {31'd0, dut.zero}, 32'd1);
    cycles(1);
    chk("tk_pcsrc", {31'd0, dut.pc_src}, 32'd1);
    chk("tk_target", dut.pc_target, 32'hFFFFFFF4);
    cycles(1);
    chk("tk_pc", dut.pc_cur, 32'hFFFFFFF4);
    // not-taken beq
    clear_all();
    dut.imem[0] = 32'h00208863;
    dut.imem[1] = 32'h00208863;
    dut.regs[1] = 32'd42;
    dut.regs[2] = 32'd43;
    start();
    cycles(1);
    chk("nt_imm", dut.imm_ext, 32'h10);
    chk("nt_a", dut.a, 32'h2A);
    chk("nt_b", dut.b, 32'h2B);
    chk("nt_zero", {31'd0, dut.zero}, 32'd0);
    cycles(1);
    chk("nt_pcsrc", {31'd0, dut.pc_src}, 32'd0);
    chk("nt_target", dut.pc_target, 32'h10);
    cycles(1);
    chk("nt_pc", dut.pc_cur, 32'd4);
    chk("nt_target2", dut.pc_target, 32'h14);
    // zero ALU result must not redirect
    clear_all();
    dut.imem[0] = enc_r(7'h20, 3'b000, 5'd1, 5'd1, 5'd1);
    dut.regs[1] = 32'd1;
    start();
    cycles(2);
    chk("zr_zero", {31'd0, dut.zero}, 32'd1);
    chk("zr_pcsrc", {31'd0, dut.pc_src}, 32'd0);
    cycles(1);
    chk("zr_pc_wb", dut.pc_cur, 32'd0);
    cycles(1);
    chk("zr_pc", dut.pc_cur, 32'd4);
    chk("zr_x1", dut.regs[1], 32'd0);
    // addi / sw / lw chain
    clear_all();
    dut.imem[0] = enc_i(12'd8, 5'd0, 3'b000, 5'd5, 7'b0010011);
    dut.imem[1] = enc_s(12'd4, 5'd5, 5'd0);
    dut.imem[2] = enc_i(12'd4, 5'd0, 3'b010, 5'd6, 7'b0000011);
    start();
    cycles(12);
    chk("mem_pc12", dut.pc_cur, 32'd8);
    cycles(1);
    chk("mem_pc", dut.pc_cur, 32'd12);
    chk("mem_x5", dut.regs[5], 32'd8);
    chk("mem_dmem1", dut.dmem[1], 32'd8);
    chk("mem_x6", dut.regs[6], 32'd8);
    // reset during ALUWB aborts the write and restarts from FETCH
    clear_all();
    dut.imem[0] = enc_r(7'h00, 3'b000, 5'd3, 5'd1, 5'd2);
    dut.regs[1] = 32'd5;
    dut.regs[2] = 32'd6;
    dut.regs[3] = 32'hDEAD;
    start();
    cycles(3);
    reset = 1'b0;
    #1;
    chk("ra_pc_now", dut.pc_cur, 32'd0);
    cycles(2);
    chk("ra_x3", dut.regs[3], 32'hDEAD);
    reset = 1'b1;
    cycles(3);
    chk("ra_x3_hold", dut.regs[3], 32'hDEAD);
    chk("ra_pc_hold", dut.pc_cur, 32'd0);
    cycles(1);
    chk("ra_x3_new", dut.regs[3], 32'd11);
    chk("ra_pc_new", dut.pc_cur, 32'd4);
    // reset during MEMWR aborts the store
    clear_all();
    dut.imem[0] = enc_s(12'd0, 5'd1, 5'd0);
    dut.regs[1] = 32'd77;
    start();
    cycles(3);
    reset = 1'b0;
    cycles(2);
    chk("rw_dmem0", dut.dmem[0], 32'd0);
    // unknown opcode stalls in FETCH
    clear_all();
    dut.imem[0] = 32'hFFFFFFFF;
    start();
    cycles(10);
    chk("unk_pc", dut.pc_cur, 32'd0);
    // random programs against the ISA model
    for (int t = 0; t < 20; t++) begin
      clear_all();
      for (int i = 0; i < 64; i++) begin
        prog[i] = rand_ins();
        dut.imem[i] = enc(prog[i]);
        m_dmem[i] = $urandom;
        dut.dmem[i] = m_dmem[i];
      end
      m_regs[0] = '0;
      for (int r = 1; r < 32; r++) begin
        m_regs[r] = $urandom;
        dut.regs[r] = m_regs[r];
      end
      m_pc = '0;
      cyc = 0;
      for (int n = 0; n < 30; n++) cyc += step();
      start();
      cycles(cyc);
      chk($sformatf("rnd%0d_pc", t), dut.pc_cur, m_pc);
      for (int r = 1; r < 8; r++) chk($sformatf("rnd%0d_x%0d", t, r), dut.regs[r], m_regs[r]);
      for (int i = 0; i < 64; i++) chk($sformatf("rnd%0d_dmem%0d", t, i), dut.dmem[i], m_dmem[i]);
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
